// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings and constants for the IF/MEM memory bus arbiter
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int BUS_DATA_W         = 64;
  localparam int BUS_STRB_W         = BUS_DATA_W / 8;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] limit);
    return (v >= limit) ? limit : v + 4'd1;
  endfunction

endpackage

// File: rtl/rr_starve_guard.sv
// rtl/rr_starve_guard.sv - data-first grant decision with a starvation guard for the fetch port
module rr_starve_guard
  import mem_bus_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_inst,
  output logic grant_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  always_comb begin
    grant_inst   = grant_en & inst_req & (~data_req | (starve_cnt_q == LIMIT));
    grant_data   = grant_en & data_req & ~grant_inst;
    starve_cnt_d = starve_cnt_q;
    // Only data grants that overtake a waiting fetch count toward the limit.
    if (!inst_req || grant_inst) begin
      starve_cnt_d = '0;
    end else if (grant_data) begin
      starve_cnt_d = sat_inc4(starve_cnt_q, LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding 64-bit memory bus shared by IF fetch and MEM load/store
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                br_e,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_rvalid,
  output logic                stallreq_if,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_rvalid,
  output logic                stallreq_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ready,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  logic [1:0]          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                drop_q, drop_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [DATA_W/8-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

  logic grant_en;
  logic grant_inst;
  logic grant_data;
  logic accept;
  logic complete;

  rr_starve_guard #(
    .STARVE_MAX(STARVE_MAX)
  ) u_guard (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_en  (grant_en),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  assign grant_en = (state_q == ST_IDLE);
  assign accept   = (state_q == ST_ADDR) & bus_ready;
  // A response arriving while reset is asserted belongs to an abandoned transaction.
  assign complete = rst_n & bus_rvalid & (accept | (state_q == ST_RESP));

  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign inst_rvalid  = complete & (owner_q == OWNER_INST) & ~drop_q & ~br_e;
  assign data_rvalid  = complete & (owner_q == OWNER_DATA);
  assign stallreq_if  = inst_req & ~inst_rvalid;
  assign stallreq_mem = data_req & ~data_rvalid;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_inst || grant_data) begin
          state_d     = ST_ADDR;
          owner_d     = grant_data ? OWNER_DATA : OWNER_INST;
          drop_d      = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = grant_data & data_we;
          bus_wstrb_d = grant_data ? data_wstrb : '0;
          bus_addr_d  = grant_data ? data_addr : inst_addr;
          bus_wdata_d = grant_data ? data_wdata : '0;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          bus_req_d = 1'b0;
          state_d   = bus_rvalid ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The bus cannot abort, so a flushed fetch runs to completion and is discarded.
    if (complete) begin
      drop_d = 1'b0;
    end else if (br_e && (owner_q == OWNER_INST) && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_INST;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule
